// File: rtl/uart_hex_tx.sv
// uart_hex_tx: reports one byte as two uppercase ASCII hex characters
// (optionally followed by CR/LF) on an 8N1 UART line. It has its own bit
// serializer. All outputs come straight from flops.
module uart_hex_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int SEND_CRLF    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] LAST_CHAR = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [1:0]    char_reg, char_next;
    logic [7:0]    byte_reg, byte_next;
    logic          serial_reg, serial_next;
    logic          active_reg, active_next;
    logic          ready_reg, ready_next;
    logic          done_reg, done_next;
    logic [7:0]    char_bits;

    // One nibble as an uppercase ASCII hex digit ('A' - 10 == 0x37).
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character at a given position in the outgoing sequence.
    function automatic logic [7:0] char_code(input logic [1:0] idx, input logic [7:0] b);
        logic [7:0] c;
        case (idx)
            2'd0:    c = hex_char(b[7:4]);
            2'd1:    c = hex_char(b[3:0]);
            2'd2:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    // State, counters and registered outputs; reset drops the line to idle-high at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            char_reg   <= '0;
            byte_reg   <= '0;
            serial_reg <= 1'b1;
            active_reg <= 1'b0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            char_reg   <= char_next;
            byte_reg   <= byte_next;
            serial_reg <= serial_next;
            active_reg <= active_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic: sequencing of start/data/stop bits across the characters.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        char_next  = char_reg;
        byte_next  = byte_reg;
        case (state_reg)
            IDLE: begin
                if (i_valid && ready_reg) begin
                    state_next = START;
                    baud_next  = '0;
                    bit_next   = '0;
                    char_next  = '0;
                    byte_next  = i_byte;
                end
            end
            START: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            DATA: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    bit_next  = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (char_reg == LAST_CHAR) begin
                        state_next = DONE;
                    end else begin
                        char_next  = char_reg + 2'd1;
                        state_next = START;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so the output flops track the state flop.
    always_comb begin
        char_bits   = char_code(char_next, byte_next);
        serial_next = 1'b1;
        active_next = 1'b0;
        ready_next  = 1'b0;
        done_next   = 1'b0;
        case (state_next)
            IDLE: begin
                ready_next = 1'b1;
            end
            START: begin
                serial_next = 1'b0;
                active_next = 1'b1;
            end
            DATA: begin
                serial_next = char_bits[bit_next];
                active_next = 1'b1;
            end
            STOP: begin
                active_next = 1'b1;
            end
            default: begin
                done_next = 1'b1;
            end
        endcase
    end

    assign o_ready     = ready_reg;
    assign o_tx_serial = serial_reg;
    assign o_tx_active = active_reg;
    assign o_done      = done_reg;

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: random bytes through two instances (with and without CR/LF)
// compared against a per-cycle line model built from the character list.
module tb_uart_hex_tx;

    localparam int C = 4;

    logic       clk;
    logic       rst   [2];
    logic       valid [2];
    logic [7:0] din   [2];
    logic       ready [2];
    logic       ser   [2];
    logic       active[2];
    logic       done  [2];

    int total = 0;
    int bad   = 0;
    logic samples [0:399];

    uart_hex_tx #(.CLKS_PER_BIT(C), .SEND_CRLF(1)) dut (
        .i_clk(clk), .i_rst(rst[0]), .i_byte(din[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_tx_serial(ser[0]), .o_tx_active(active[0]), .o_done(done[0])
    );

    uart_hex_tx #(.CLKS_PER_BIT(C), .SEND_CRLF(0)) dut_nocrlf (
        .i_clk(clk), .i_rst(rst[1]), .i_byte(din[1]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_tx_serial(ser[1]), .o_tx_active(active[1]), .o_done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the text the host should see for a byte.
    function automatic logic [7:0] model_char(input logic [7:0] b, input int idx);
        int n;
        if (idx == 2) return 8'h0D;
        if (idx == 3) return 8'h0A;
        n = (idx == 0) ? int'(b) / 16 : int'(b) % 16;
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    // Reference: expected line level t cycles after the first start-bit cycle.
    function automatic logic model_line(input logic [7:0] b, input int t);
        int c, k;
        logic [7:0] ch;
        c  = t / (10 * C);
        k  = (t % (10 * C)) / C;
        ch = model_char(b, c);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return ch[k - 1];
    endfunction

    // Continuous invariants on both instances.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            check("ready_and_active", {31'd0, ready[s] & active[s]}, 32'd0);
            check("line_low_inactive", {31'd0, ~active[s] & ~ser[s]}, 32'd0);
        end
    end

    // Follow one sequence from the accept to the DONE cycle and compare it with the model.
    task automatic capture(input int s, input logic [7:0] exp_b, input bit hold,
                           input logic [7:0] next_b, input int exp_gap);
        int gap, len, nchars, errs, dcnt;
        logic [7:0] v;
        gap    = 0;
        len    = 0;
        errs   = 0;
        dcnt   = 0;
        nchars = (s == 0) ? 4 : 2;
        @(negedge clk);
        while (!active[s] && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        check("start_gap", gap, exp_gap);
        if (!hold) valid[s] = 1'b0;
        while (active[s] && len < 1000) begin
            if (len < 400) samples[len] = ser[s];
            if (done[s]) dcnt++;
            len++;
            if (len == 40)  din[s] = 8'($urandom);
            if (len == 100) din[s] = next_b;
            @(negedge clk);
        end
        check("active_len", len, nchars * 10 * C);
        check("done_early", dcnt, 0);
        check("done_pulse", {31'd0, done[s]}, 32'd1);
        check("ready_in_done", {31'd0, ready[s]}, 32'd0);
        check("line_in_done", {31'd0, ser[s]}, 32'd1);
        for (int t = 0; t < len && t < 400; t++)
            if (samples[t] !== model_line(exp_b, t)) errs++;
        check("waveform", errs, 0);
        for (int c = 0; c < nchars; c++) begin
            v = 8'd0;
            for (int k = 0; k < 8; k++) v[k] = samples[c * 10 * C + (k + 1) * C + C / 2];
            check("char", {24'd0, v}, {24'd0, model_char(exp_b, c)});
        end
        $display("seq dut=%0d byte=%02h len=%0d gap=%0d wave_errs=%0d", s, exp_b, len, gap, errs);
    endtask

    initial begin
        logic [7:0] rb;
        for (int s = 0; s < 2; s++) begin
            rst[s]   = 1'b1;
            valid[s] = 1'b0;
            din[s]   = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_line", {31'd0, ser[s]}, 32'd1);
            check("rst_ready", {31'd0, ready[s]}, 32'd1);
            check("rst_active", {31'd0, active[s]}, 32'd0);
            check("rst_done", {31'd0, done[s]}, 32'd0);
            rst[s] = 1'b0;
        end

        // Idle after reset: nothing goes out.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_line", {31'd0, ser[0]}, 32'd1);
            check("idle_ready", {31'd0, ready[0]}, 32'd1);
            check("idle_done", {31'd0, done[0]}, 32'd0);
        end

        // Directed byte 0x3A -> "3A\r\n".
        din[0] = 8'h3A; valid[0] = 1'b1;
        capture(0, 8'h3A, 1'b0, 8'h11, 0);
        @(negedge clk);
        check("ready_after_done", {31'd0, ready[0]}, 32'd1);
        check("done_one_cycle", {31'd0, done[0]}, 32'd0);

        // Back-to-back with i_valid held: 0x00 then 0xFF, 2 idle cycles between.
        din[0] = 8'h00; valid[0] = 1'b1;
        capture(0, 8'h00, 1'b1, 8'hFF, 0);
        capture(0, 8'hFF, 1'b0, 8'h22, 1);

        // Random bytes on both instances.
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            @(negedge clk);
            din[0] = rb; valid[0] = 1'b1;
            capture(0, rb, 1'b0, 8'($urandom), 0);
        end
        @(negedge clk);
        din[1] = 8'h9C; valid[1] = 1'b1;
        capture(1, 8'h9C, 1'b0, 8'h33, 0);
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            @(negedge clk);
            din[1] = rb; valid[1] = 1'b1;
            capture(1, rb, 1'b0, 8'($urandom), 0);
        end

        // Reset during bit 3 of the second character.
        @(negedge clk);
        din[0] = 8'h77; valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        check("pre_abort_active", {31'd0, active[0]}, 32'd1);
        repeat (57) @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("abort_line", {31'd0, ser[0]}, 32'd1);
        check("abort_ready", {31'd0, ready[0]}, 32'd1);
        check("abort_active", {31'd0, active[0]}, 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {31'd0, active[0]}, 32'd0);
        end
        din[0] = 8'h5E; valid[0] = 1'b1;
        capture(0, 8'h5E, 1'b0, 8'h44, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
